control_ajustes: RTL and testbench
==================================

// Module: control_ajustes
// PURPOSE
//  Configuration controller for the image-processing datapath. Consumes the debounced button code from the
//  button selector and keeps three settings: brightness offset, binarisation threshold and invert flag.
//  Applies step/saturation rules and optional auto-repeat on held buttons. Edits go to shadow registers;
//  the active outputs load from them only on FRAME_SYNC, so a frame is never processed with mixed settings.
// PARAMETERS
//  STEP_BRILLO  8           brightness step per action (unsigned, 1..64)
//  STEP_UMBRAL  4           threshold step per action (unsigned, 1..64)
//  UMBRAL_INIT  128         threshold value after reset
//  REPEAT_DLY   25_000_000  cycles a button is held before first auto-repeat (0.5 s @ 50 MHz)
//  REPEAT_RATE  5_000_000   cycles between auto-repeats (100 ms @ 50 MHz)
// PORTS
//  CLK          in   1  system clock
//  RST_N        in   1  synchronous reset, active low
//  BOTON_SEL    in   3  0 none, 1 BRILLO+, 2 BRILLO-, 3 UMBRAL+, 4 UMBRAL-, 5 INVERTIR; 6,7 treated as 0
//  FRAME_SYNC   in   1  one-cycle pulse at frame boundary (vertical blanking)
//  BRILLO       out  9  active brightness offset, signed two's complement, range -128..+127
//  UMBRAL       out  8  active threshold, unsigned 0..255
//  INVERTIR_ON  out  1  active invert flag
//  CAMBIO       out  1  one-cycle pulse: active settings changed on this load
// BEHAVIOUR
//  Reset (RST_N low at a CLK edge): BRILLO=0, UMBRAL=UMBRAL_INIT, INVERTIR_ON=0, CAMBIO=0;
//   shadows equal the same values; FSM to IDLE; counters cleared. Reset mid-hold aborts with no action.
//  BOTON_SEL registered once (code_q). Decisions use code_q; an action updates the shadow on the edge
//   after code_q becomes valid -> shadow changes 2 edges after BOTON_SEL.
//  FSM: IDLE  : code_q!=0 -> APLICA.
//       APLICA: apply action once (1 cycle); code_q==0 -> IDLE, else -> ESPERA, counter cleared.
//       ESPERA: count cycles; code_q==0 -> IDLE; code_q changed to another nonzero code -> APLICA;
//               count==REPEAT_DLY-1 and code in 1..4 -> REPITE, counter cleared.
//       REPITE: count cycles; code_q==0 -> IDLE; code changed -> APLICA;
//               count==REPEAT_RATE-1 -> apply action, counter cleared, stay.
//  Actions: BRILLO+/- add/sub STEP_BRILLO, saturate at +127/-128 (10-bit intermediate, no wrap).
//   UMBRAL+/- add/sub STEP_UMBRAL, saturate at 255/0 (9-bit intermediate, no wrap).
//   INVERTIR toggles shadow flag once per press; never auto-repeats (stays in ESPERA until release).
//  Saturated no-op actions leave the shadow unchanged.
//  Active load: on the edge after a cycle with FRAME_SYNC=1, active <= shadow as held before that edge;
//   an action on the same edge lands in the shadow and reaches the outputs at the next FRAME_SYNC.
//   CAMBIO=1 for exactly that one cycle iff any active field differs from its old value.
//  FRAME_SYNC during reset ignored. Consecutive-cycle FRAME_SYNC pulses each perform a load.
// CONFIGURATION
//  AUTO_REPEAT_EN defined  : ESPERA/REPITE auto-repeat as above.
//  AUTO_REPEAT_EN undefined: no REPITE state, no repeat counter; exactly one action per press;
//   FSM stays in ESPERA until code_q==0 or code_q changes to another nonzero code.
// TESTING  (sim with REPEAT_DLY=10, REPEAT_RATE=4, defaults otherwise)
//  1 Reset, then BOTON_SEL=1 for 3 cycles, then 0, FRAME_SYNC pulse -> BRILLO=8, UMBRAL=128, CAMBIO pulse x1.
//  2 16 separate UMBRAL+ presses from reset, then FRAME_SYNC -> UMBRAL=192 (128+64); 40 more presses -> 255, no wrap;
//    BRILLO- 20 presses -> -128, stays -128.
//  3 AUTO_REPEAT_EN: hold BOTON_SEL=1 for 30 cycles -> 1 + 5 actions (first at press, then at 10 and every 4) ->
//    shadow BRILLO=48; same test without macro -> BRILLO=8.
//  4 Hold BOTON_SEL=5 for 40 cycles -> INVERTIR_ON=1 after next FRAME_SYNC only (single toggle); second press -> 0.
//  5 Action and FRAME_SYNC on same edge -> outputs keep old value, CAMBIO=0 if nothing else pending;
//    next FRAME_SYNC loads new value with CAMBIO=1.
//  6 RST_N low during REPITE with pending shadow edits -> all outputs/shadows back to reset values, next FRAME_SYNC gives CAMBIO=0.

Source files
------------

// File: rtl/control_ajustes.sv
// Settings controller: brightness/threshold/invert shadow registers with frame-synchronous load.
// Optional auto-repeat on held buttons is enabled by defining AUTO_REPEAT_EN.
module control_ajustes #(
  parameter int unsigned STEP_BRILLO = 8,
  parameter int unsigned STEP_UMBRAL = 4,
  parameter int unsigned UMBRAL_INIT = 128,
  parameter int unsigned REPEAT_DLY  = 25_000_000,
  parameter int unsigned REPEAT_RATE = 5_000_000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [2:0]        BOTON_SEL,
  input  logic              FRAME_SYNC,
  output logic signed [8:0] BRILLO,
  output logic [7:0]        UMBRAL,
  output logic              INVERTIR_ON,
  output logic              CAMBIO
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] APLICA = 2'd1;
  localparam logic [1:0] ESPERA = 2'd2;
`ifdef AUTO_REPEAT_EN
  localparam logic [1:0]  REPITE    = 2'd3;
  localparam logic [31:0] DLY_LAST  = 32'(REPEAT_DLY - 1);
  localparam logic [31:0] RATE_LAST = 32'(REPEAT_RATE - 1);
`endif

  localparam logic signed [9:0] STEP_B = 10'(STEP_BRILLO);
  localparam logic [8:0]        STEP_U = 9'(STEP_UMBRAL);
  localparam logic [7:0]        U_INIT = 8'(UMBRAL_INIT);

  logic [2:0]        code_p0;
  logic [2:0]        act_code;
  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              do_act;
  logic signed [8:0] sh_brillo;
  logic [7:0]        sh_umbral;
  logic              sh_inv;
  logic signed [9:0] br_ext;
`ifdef AUTO_REPEAT_EN
  logic [31:0]       cnt;
  logic              cnt_clr;
`endif

  function automatic logic signed [8:0] sat_brillo(input logic signed [9:0] v);
    if (v > 10'sd127)
      sat_brillo = 9'sd127;
    else if (v < -10'sd128)
      sat_brillo = -9'sd128;
    else
      sat_brillo = $signed(v[8:0]);
  endfunction

  // A carry or borrow into bit 8 marks the out-of-range case.
  function automatic logic [7:0] sat_umbral(input logic [7:0] u, input logic up);
    logic [8:0] t;
    if (up) begin
      t = {1'b0, u} + STEP_U;
      sat_umbral = t[8] ? 8'hFF : t[7:0];
    end else begin
      t = {1'b0, u} - STEP_U;
      sat_umbral = t[8] ? 8'h00 : t[7:0];
    end
  endfunction

  assign br_ext = {sh_brillo[8], sh_brillo};

  always_comb begin
    state_nxt = state;
    do_act    = 1'b0;
`ifdef AUTO_REPEAT_EN
    cnt_clr   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (code_p0 != 3'd0) begin
          state_nxt = APLICA;
          do_act    = 1'b1;
        end
      end
      APLICA: begin
        if (code_p0 == 3'd0)
          state_nxt = IDLE;
        else begin
          state_nxt = ESPERA;
`ifdef AUTO_REPEAT_EN
          cnt_clr   = 1'b1;
`endif
        end
      end
      ESPERA: begin
        if (code_p0 == 3'd0)
          state_nxt = IDLE;
        else if (code_p0 != act_code) begin
          state_nxt = APLICA;
          do_act    = 1'b1;
        end
`ifdef AUTO_REPEAT_EN
        // Entering REPITE is itself the first auto-repeat action.
        else if (cnt == DLY_LAST && code_p0 != 3'd5) begin
          state_nxt = REPITE;
          do_act    = 1'b1;
          cnt_clr   = 1'b1;
        end
`endif
      end
`ifdef AUTO_REPEAT_EN
      REPITE: begin
        if (code_p0 == 3'd0)
          state_nxt = IDLE;
        else if (code_p0 != act_code) begin
          state_nxt = APLICA;
          do_act    = 1'b1;
        end else if (cnt == RATE_LAST) begin
          do_act  = 1'b1;
          cnt_clr = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      code_p0     <= 3'd0;
      act_code    <= 3'd0;
      state       <= IDLE;
`ifdef AUTO_REPEAT_EN
      cnt         <= '0;
`endif
      sh_brillo   <= '0;
      sh_umbral   <= U_INIT;
      sh_inv      <= 1'b0;
      BRILLO      <= '0;
      UMBRAL      <= U_INIT;
      INVERTIR_ON <= 1'b0;
      CAMBIO      <= 1'b0;
    end else begin
      // Stage p0: button code capture; codes 6 and 7 fold to "none".
      code_p0 <= (BOTON_SEL > 3'd5) ? 3'd0 : BOTON_SEL;
      state   <= state_nxt;
      if (state_nxt == APLICA)
        act_code <= code_p0;
`ifdef AUTO_REPEAT_EN
      cnt <= cnt_clr ? '0 : cnt + 32'd1;
`endif
      if (do_act) begin
        case (code_p0)
          3'd1:    sh_brillo <= sat_brillo(br_ext + STEP_B);
          3'd2:    sh_brillo <= sat_brillo(br_ext - STEP_B);
          3'd3:    sh_umbral <= sat_umbral(sh_umbral, 1'b1);
          3'd4:    sh_umbral <= sat_umbral(sh_umbral, 1'b0);
          3'd5:    sh_inv    <= ~sh_inv;
          default: ;
        endcase
      end
      // Active outputs take the shadow as it stood before this edge.
      CAMBIO <= 1'b0;
      if (FRAME_SYNC) begin
        BRILLO      <= sh_brillo;
        UMBRAL      <= sh_umbral;
        INVERTIR_ON <= sh_inv;
        CAMBIO      <= (BRILLO != sh_brillo) || (UMBRAL != sh_umbral) ||
                       (INVERTIR_ON != sh_inv);
      end
    end
  end

endmodule

// File: tb/tb_control_ajustes.sv
// Scoreboard bench for control_ajustes (REPEAT_DLY=10, REPEAT_RATE=4); honours AUTO_REPEAT_EN.
module tb_control_ajustes;

  localparam int SB = 8;
  localparam int SU = 4;

  typedef struct packed {
    logic signed [8:0] b;
    logic [7:0]        u;
    logic              i;
    logic              c;
  } snap_t;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic [2:0]        BOTON_SEL;
  logic              FRAME_SYNC;
  logic signed [8:0] BRILLO;
  logic [7:0]        UMBRAL;
  logic              INVERTIR_ON;
  logic              CAMBIO;

  int total = 0;
  int bad   = 0;
  snap_t sbq[$];
  snap_t obs, exp_s;

  int m_sb, m_su, m_ab, m_au;
  bit m_si, m_ai;

  control_ajustes #(
    .STEP_BRILLO(SB), .STEP_UMBRAL(SU), .UMBRAL_INIT(128),
    .REPEAT_DLY(10), .REPEAT_RATE(4)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .BOTON_SEL(BOTON_SEL), .FRAME_SYNC(FRAME_SYNC),
    .BRILLO(BRILLO), .UMBRAL(UMBRAL), .INVERTIR_ON(INVERTIR_ON), .CAMBIO(CAMBIO)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic snap_t cur();
    snap_t s;
    s.b = BRILLO; s.u = UMBRAL; s.i = INVERTIR_ON; s.c = CAMBIO;
    return s;
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("b=%0d u=%0d i=%0b c=%0b", s.b, s.u, s.i, s.c);
  endfunction

  task automatic model_act(int code);
    case (code)
      1: m_sb = (m_sb + SB > 127) ? 127 : m_sb + SB;
      2: m_sb = (m_sb - SB < -128) ? -128 : m_sb - SB;
      3: m_su = (m_su + SU > 255) ? 255 : m_su + SU;
      4: m_su = (m_su - SU < 0) ? 0 : m_su - SU;
      5: m_si = !m_si;
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_sb = 0; m_su = 128; m_si = 0;
    m_ab = 0; m_au = 128; m_ai = 0;
  endtask

  // FRAME_SYNC asserted during reset must be ignored.
  task automatic do_reset();
    RST_N = 1'b0; BOTON_SEL = 3'd0; FRAME_SYNC = 1'b1;
    repeat (3) tick();
    RST_N = 1'b1; FRAME_SYNC = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic press(int code, int hold);
    BOTON_SEL = 3'(code);
    repeat (hold) tick();
    BOTON_SEL = 3'd0;
    repeat (3) tick();
    model_act(code);
  endtask

  task automatic push_load();
    snap_t e;
    e.c = (m_sb != m_ab) || (m_su != m_au) || (m_si != m_ai);
    m_ab = m_sb; m_au = m_su; m_ai = m_si;
    e.b = 9'(m_ab); e.u = 8'(m_au); e.i = m_ai;
    sbq.push_back(e);
  endtask

  task automatic frame();
    push_load();
    FRAME_SYNC = 1'b1;
    tick();
    FRAME_SYNC = 1'b0;
  endtask

  task automatic test_reset();
    snap_t r;
    do_reset();
    r.b = 9'sd0; r.u = 8'd128; r.i = 1'b0; r.c = 1'b0;
    obs = cur(); total++;
    if (obs !== r) begin bad++; $display("FAIL reset_vals: got %s want %s", fmt(obs), fmt(r)); end
    frame();
    obs = cur(); exp_s = sbq.pop_front(); total++;
    if (obs !== exp_s) begin bad++; $display("FAIL reset_load: got %s want %s", fmt(obs), fmt(exp_s)); end
  endtask

  task automatic test_brillo_single();
    do_reset();
    press(1, 3);
    frame();
    obs = cur(); exp_s = sbq.pop_front(); total++;
    if (obs !== exp_s) begin bad++; $display("FAIL brillo_load: got %s want %s", fmt(obs), fmt(exp_s)); end
    tick();
    total++;
    if (CAMBIO !== 1'b0) begin bad++; $display("FAIL cambio_width: got %0b want 0", CAMBIO); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 16; k++) press(3, 1);
    frame();
    obs = cur(); exp_s = sbq.pop_front(); total++;
    if (obs !== exp_s) begin bad++; $display("FAIL umbral_16: got %s want %s", fmt(obs), fmt(exp_s)); end
    for (int k = 0; k < 40; k++) press(3, 1);
    frame();
    obs = cur(); exp_s = sbq.pop_front(); total++;
    if (obs !== exp_s) begin bad++; $display("FAIL umbral_sat: got %s want %s", fmt(obs), fmt(exp_s)); end
    for (int k = 0; k < 20; k++) press(2, 1);
    frame();
    obs = cur(); exp_s = sbq.pop_front(); total++;
    if (obs !== exp_s) begin bad++; $display("FAIL brillo_sat: got %s want %s", fmt(obs), fmt(exp_s)); end
    press(2, 1);
    frame();
    obs = cur(); exp_s = sbq.pop_front(); total++;
    if (obs !== exp_s) begin bad++; $display("FAIL brillo_hold_min: got %s want %s", fmt(obs), fmt(exp_s)); end
  endtask

  task automatic test_auto_repeat();
    int n_act;
`ifdef AUTO_REPEAT_EN
    n_act = 6;
`else
    n_act = 1;
`endif
    do_reset();
    BOTON_SEL = 3'd1;
    repeat (30) tick();
    BOTON_SEL = 3'd0;
    repeat (4) tick();
    for (int k = 0; k < n_act; k++) model_act(1);
    frame();
    obs = cur(); exp_s = sbq.pop_front(); total++;
    if (obs !== exp_s) begin bad++; $display("FAIL auto_repeat: got %s want %s", fmt(obs), fmt(exp_s)); end
  endtask

  task automatic test_invert();
    do_reset();
    press(5, 40);
    total++;
    if (INVERTIR_ON !== 1'b0) begin bad++; $display("FAIL inv_before_sync: got %0b want 0", INVERTIR_ON); end
    frame();
    obs = cur(); exp_s = sbq.pop_front(); total++;
    if (obs !== exp_s) begin bad++; $display("FAIL inv_on: got %s want %s", fmt(obs), fmt(exp_s)); end
    press(5, 1);
    frame();
    obs = cur(); exp_s = sbq.pop_front(); total++;
    if (obs !== exp_s) begin bad++; $display("FAIL inv_off: got %s want %s", fmt(obs), fmt(exp_s)); end
  endtask

  task automatic test_same_edge();
    do_reset();
    BOTON_SEL = 3'd3;
    tick();
    FRAME_SYNC = 1'b1;
    push_load();
    tick();
    FRAME_SYNC = 1'b0;
    BOTON_SEL  = 3'd0;
    obs = cur(); exp_s = sbq.pop_front(); total++;
    if (obs !== exp_s) begin bad++; $display("FAIL same_edge_old: got %s want %s", fmt(obs), fmt(exp_s)); end
    model_act(3);
    repeat (3) tick();
    frame();
    obs = cur(); exp_s = sbq.pop_front(); total++;
    if (obs !== exp_s) begin bad++; $display("FAIL same_edge_new: got %s want %s", fmt(obs), fmt(exp_s)); end
  endtask

  task automatic test_reset_mid_hold();
    snap_t r;
    do_reset();
    press(3, 1);
    frame();
    obs = cur(); exp_s = sbq.pop_front(); total++;
    if (obs !== exp_s) begin bad++; $display("FAIL pre_reset_load: got %s want %s", fmt(obs), fmt(exp_s)); end
    press(4, 1);
    BOTON_SEL = 3'd1;
    repeat (20) tick();
    RST_N = 1'b0; FRAME_SYNC = 1'b1;
    repeat (2) tick();
    RST_N = 1'b1; FRAME_SYNC = 1'b0; BOTON_SEL = 3'd0;
    model_reset();
    r.b = 9'sd0; r.u = 8'd128; r.i = 1'b0; r.c = 1'b0;
    obs = cur(); total++;
    if (obs !== r) begin bad++; $display("FAIL mid_hold_reset: got %s want %s", fmt(obs), fmt(r)); end
    repeat (3) tick();
    frame();
    obs = cur(); exp_s = sbq.pop_front(); total++;
    if (obs !== exp_s) begin bad++; $display("FAIL post_reset_load: got %s want %s", fmt(obs), fmt(exp_s)); end
  endtask

  task automatic test_ignored_codes();
    do_reset();
    press(6, 2);
    press(7, 2);
    frame();
    obs = cur(); exp_s = sbq.pop_front(); total++;
    if (obs !== exp_s) begin bad++; $display("FAIL codes_6_7: got %s want %s", fmt(obs), fmt(exp_s)); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    press(1, 1);
    press(4, 1);
    push_load();
    push_load();
    FRAME_SYNC = 1'b1;
    tick();
    obs = cur(); exp_s = sbq.pop_front(); total++;
    if (obs !== exp_s) begin bad++; $display("FAIL b2b_first: got %s want %s", fmt(obs), fmt(exp_s)); end
    tick();
    FRAME_SYNC = 1'b0;
    obs = cur(); exp_s = sbq.pop_front(); total++;
    if (obs !== exp_s) begin bad++; $display("FAIL b2b_second: got %s want %s", fmt(obs), fmt(exp_s)); end
  endtask

  initial begin
    RST_N = 1'b0; BOTON_SEL = 3'd0; FRAME_SYNC = 1'b0;
    model_reset();
    test_reset();
    test_brillo_single();
    test_saturation();
    test_auto_repeat();
    test_invert();
    test_same_edge();
    test_reset_mid_hold();
    test_ignored_codes();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
